// File: rtl/lfsr_prog_gen.sv
// Run-time programmable multi-bit-per-step LFSR with loadable polynomial and seed,
// all-zero lock-up recovery and sequence period measurement.
module lfsr_prog_gen #(
    parameter int                     N_BITS_REGS  = 31,
    parameter int                     OUT_BITS     = 4,
    parameter logic [N_BITS_REGS-1:0] DEFAULT_POLY = 31'b1001000000000000000000000000000,
    parameter logic [N_BITS_REGS-1:0] DEFAULT_SEED = {1'b1, {(N_BITS_REGS-1){1'b0}}},
    parameter int                     CNT_BITS     = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in_n,
    input  logic                       ena_in,
    input  logic                       load_in,
    input  logic [N_BITS_REGS-1:0]     poly_in,
    input  logic [N_BITS_REGS-1:0]     seed_in,
    output logic signed [OUT_BITS-1:0] lfsr_out,
    output logic                       start_out,
    output logic                       lockup_out,
    output logic [CNT_BITS-1:0]        period_out,
    output logic                       period_valid_out,
    output logic                       period_sat_out
);

    logic [N_BITS_REGS-1:0] state;
    logic [N_BITS_REGS-1:0] poly_reg;
    logic [N_BITS_REGS-1:0] seed_reg;
    logic [N_BITS_REGS-1:0] next_state;
    logic [N_BITS_REGS-1:0] load_seed;
    logic [CNT_BITS-1:0]    cnt;
    logic                   cnt_max;

    // Low OUT_BITS bits are fresh feedback bits, the rest shift up by OUT_BITS per step.
    always_comb begin
        next_state = '0;
        for (int ff = 0; ff < OUT_BITS; ff++) begin
            next_state[ff] = ^(state & (poly_reg >> (OUT_BITS - 1 - ff)));
        end
        for (int ff = OUT_BITS; ff < N_BITS_REGS; ff++) begin
            next_state[ff] = state[ff-OUT_BITS];
        end
    end

    // A zero seed would lock the generator immediately, so it falls back to the default.
    assign load_seed = (seed_in == '0) ? DEFAULT_SEED : seed_in;
    assign cnt_max   = &cnt;
    assign lfsr_out  = state[OUT_BITS-1:0];
    assign start_out = ena_in & (state == seed_reg);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state            <= DEFAULT_SEED;
            seed_reg         <= DEFAULT_SEED;
            poly_reg         <= DEFAULT_POLY;
            cnt              <= '0;
            period_out       <= '0;
            lockup_out       <= 1'b0;
            period_valid_out <= 1'b0;
            period_sat_out   <= 1'b0;
        end else begin
            lockup_out       <= 1'b0;
            period_valid_out <= 1'b0;
            if (load_in) begin
                poly_reg       <= poly_in;
                seed_reg       <= load_seed;
                state          <= load_seed;
                cnt            <= '0;
                period_sat_out <= 1'b0;
            end else if (ena_in) begin
                if (state == '0) begin
                    state      <= seed_reg;
                    lockup_out <= 1'b1;
                    cnt        <= '0;
                end else begin
                    state <= next_state;
                    if (cnt_max) begin
                        period_sat_out <= 1'b1;
                    end
                    // The recurrence step itself counts, hence cnt+1; it clamps at all-ones.
                    if (next_state == seed_reg) begin
                        period_out       <= cnt_max ? cnt : cnt + CNT_BITS'(1);
                        period_valid_out <= 1'b1;
                        cnt              <= '0;
                    end else if (!cnt_max) begin
                        cnt <= cnt + CNT_BITS'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prog_gen.sv
// Scoreboard bench for lfsr_prog_gen: a behavioural model pushes expected outputs
// per cycle and they are popped and compared after each clock edge.
module tb_lfsr_prog_gen;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       rst_in_n, ena_in, load_in;
    logic [3:0] poly_in, seed_in;

    logic       lfsr_a, start_a, lock_a, pval_a, sat_a;
    logic [7:0] period_a;
    logic       lfsr_b, start_b, lock_b, pval_b, sat_b;
    logic [2:0] period_b;
    logic [2:0] lfsr_c;
    logic       start_c, lock_c, pval_c, sat_c;
    logic [7:0] period_c;

    lfsr_prog_gen #(.N_BITS_REGS(4), .OUT_BITS(1), .DEFAULT_POLY(4'b1001),
                    .DEFAULT_SEED(4'b1000), .CNT_BITS(8)) dut_a (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .ena_in(ena_in), .load_in(load_in),
        .poly_in(poly_in), .seed_in(seed_in), .lfsr_out(lfsr_a), .start_out(start_a),
        .lockup_out(lock_a), .period_out(period_a), .period_valid_out(pval_a),
        .period_sat_out(sat_a));

    lfsr_prog_gen #(.N_BITS_REGS(4), .OUT_BITS(1), .DEFAULT_POLY(4'b1001),
                    .DEFAULT_SEED(4'b1000), .CNT_BITS(3)) dut_b (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .ena_in(ena_in), .load_in(load_in),
        .poly_in(poly_in), .seed_in(seed_in), .lfsr_out(lfsr_b), .start_out(start_b),
        .lockup_out(lock_b), .period_out(period_b), .period_valid_out(pval_b),
        .period_sat_out(sat_b));

    lfsr_prog_gen #(.N_BITS_REGS(8), .OUT_BITS(3), .DEFAULT_POLY(8'b10111000),
                    .DEFAULT_SEED(8'h80), .CNT_BITS(8)) dut_c (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .ena_in(ena_in), .load_in(1'b0),
        .poly_in(8'h00), .seed_in(8'h00), .lfsr_out(lfsr_c), .start_out(start_c),
        .lockup_out(lock_c), .period_out(period_c), .period_valid_out(pval_c),
        .period_sat_out(sat_c));

    typedef struct {
        logic [3:0] state;
        logic [3:0] poly;
        logic [3:0] seed;
        int         cnt;
        int         period;
        bit         lock;
        bit         pval;
        bit         sat;
    } mdl_t;

    typedef struct {
        logic [3:0] state_a;
        bit         lock_a, pval_a, sat_a;
        int         period_a;
        logic [3:0] state_b;
        bit         lock_b, pval_b, sat_b;
        int         period_b;
        logic [7:0] state_c;
    } exp_t;

    mdl_t       ma, mb;
    logic [7:0] mc;
    exp_t       exp_q[$];
    int         tests_run = 0;
    int         failures  = 0;
    int         pval_seen = 0;
    int         lock_seen = 0;

    function automatic mdl_t mreset();
        mdl_t r;
        r.state = 4'b1000; r.poly = 4'b1001; r.seed = 4'b1000;
        r.cnt = 0; r.period = 0; r.lock = 0; r.pval = 0; r.sat = 0;
        return r;
    endfunction

    function automatic logic [3:0] nxt4(logic [3:0] s, logic [3:0] p);
        return {s[2:0], ^(s & p)};
    endfunction

    function automatic logic [7:0] nxt8(logic [7:0] s, logic [7:0] p);
        logic [7:0] r;
        r[7:3] = s[4:0];
        for (int ff = 0; ff < 3; ff++) r[ff] = ^(s & (p >> (2 - ff)));
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit ena, bit load, logic [3:0] pin,
                                   logic [3:0] sin, int cmax);
        mdl_t       r;
        logic [3:0] n;
        r = m;
        r.lock = 0;
        r.pval = 0;
        if (load) begin
            r.poly  = pin;
            r.seed  = (sin == 4'b0000) ? 4'b1000 : sin;
            r.state = r.seed;
            r.cnt   = 0;
            r.sat   = 0;
        end else if (ena) begin
            if (m.state == 4'b0000) begin
                r.state = m.seed;
                r.lock  = 1;
                r.cnt   = 0;
            end else begin
                n = nxt4(m.state, m.poly);
                r.state = n;
                if (m.cnt == cmax) r.sat = 1;
                if (n == m.seed) begin
                    r.period = (m.cnt == cmax) ? cmax : m.cnt + 1;
                    r.pval   = 1;
                    r.cnt    = 0;
                end else if (m.cnt != cmax) begin
                    r.cnt = m.cnt + 1;
                end
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then compare them.
    task automatic applyStimulus(input bit ena, input bit load, input logic [3:0] pin,
                                 input logic [3:0] sin);
        exp_t e;
        ena_in  = ena;
        load_in = load;
        poly_in = pin;
        seed_in = sin;
        #1;
        checkOutput("start_a", {31'd0, start_a}, {31'd0, ena & (ma.state == ma.seed)});
        checkOutput("start_b", {31'd0, start_b}, {31'd0, ena & (mb.state == mb.seed)});
        ma = mstep(ma, ena, load, pin, sin, 255);
        mb = mstep(mb, ena, load, pin, sin, 7);
        if (ena) mc = (mc == 8'h00) ? 8'h80 : nxt8(mc, 8'b10111000);
        e.state_a = ma.state; e.lock_a = ma.lock; e.pval_a = ma.pval;
        e.sat_a = ma.sat; e.period_a = ma.period;
        e.state_b = mb.state; e.lock_b = mb.lock; e.pval_b = mb.pval;
        e.sat_b = mb.sat; e.period_b = mb.period;
        e.state_c = mc;
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            checkOutput("lfsr_a",   {31'd0, lfsr_a},  {31'd0, e.state_a[0]});
            checkOutput("lock_a",   {31'd0, lock_a},  {31'd0, e.lock_a});
            checkOutput("pval_a",   {31'd0, pval_a},  {31'd0, e.pval_a});
            checkOutput("sat_a",    {31'd0, sat_a},   {31'd0, e.sat_a});
            checkOutput("period_a", {24'd0, period_a}, e.period_a);
            checkOutput("lfsr_b",   {31'd0, lfsr_b},  {31'd0, e.state_b[0]});
            checkOutput("lock_b",   {31'd0, lock_b},  {31'd0, e.lock_b});
            checkOutput("pval_b",   {31'd0, pval_b},  {31'd0, e.pval_b});
            checkOutput("sat_b",    {31'd0, sat_b},   {31'd0, e.sat_b});
            checkOutput("period_b", {29'd0, period_b}, e.period_b);
            checkOutput("lfsr_c",   {29'd0, lfsr_c},  {29'd0, e.state_c[2:0]});
        end
        if (pval_a) pval_seen++;
        if (lock_a) lock_seen++;
        @(negedge clk_in);
    endtask

    initial begin
        rst_in_n = 1'b0;
        ena_in   = 1'b0;
        load_in  = 1'b0;
        poly_in  = 4'b0000;
        seed_in  = 4'b0000;
        ma = mreset();
        mb = mreset();
        mc = 8'h80;

        #1;
        checkOutput("rst_lfsr",   {31'd0, lfsr_a},  32'd0);
        checkOutput("rst_period", {24'd0, period_a}, 32'd0);
        checkOutput("rst_flags",  {29'd0, lock_a, pval_a, sat_a}, 32'd0);
        checkOutput("rst_start",  {31'd0, start_a}, 32'd0);
        checkOutput("rst_lfsr_c", {29'd0, lfsr_c},  32'd0);

        @(negedge clk_in);
        rst_in_n = 1'b1;

        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        checkOutput("pval_count_40", pval_seen, 32'd2);
        checkOutput("lock_count_40", lock_seen, 32'd0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);

        applyStimulus(1'b1, 1'b1, 4'b1001, 4'b0000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);

        lock_seen = 0;
        applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0001);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        checkOutput("lock_count_zero_poly", lock_seen, 32'd1);

        applyStimulus(1'b1, 1'b1, 4'b1001, 4'b1000);
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);

        // Asynchronous reset while the clock is low: outputs must clear before any edge.
        ena_in = 1'b1;
        #2;
        rst_in_n = 1'b0;
        #1;
        checkOutput("async_lfsr",   {31'd0, lfsr_a},  32'd0);
        checkOutput("async_period", {24'd0, period_a}, 32'd0);
        checkOutput("async_sat_b",  {31'd0, sat_b},   32'd0);
        checkOutput("async_start",  {31'd0, start_a}, 32'd1);
        ma = mreset();
        mb = mreset();
        mc = 8'h80;
        @(negedge clk_in);
        rst_in_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
